tlb: RTL
========

# tlb

16-entry fully associative MIPS32 joint TLB that sits directly beside the CP0 block. It takes CP0's write-port fields (EntryHi/EntryLo0/EntryLo1/Index) and returns read-port fields for TLBR. It serves two lookup ports:
- s0: instruction fetch, or data translation through the pipeline.
- s1: data access and TLBP; `s1_found`/`s1_index` return to CP0 via the writeback bus.

It also provides a free-running random index for TLBWR.

## Interface
- `TLBNUM`, 16: number of entries; index width `IW = log2(TLBNUM)` (4 at default).
- `clk`  in  1  system clock, all state on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s0_vpn2`  in  19  lookup VA[31:13]; `s0_odd_page` in 1 VA[12]; `s0_asid` in 8 current ASID.
- `s0_found`  out  1  hit; `s0_index` out IW; `s0_pfn` out 20; `s0_c` out 3; `s0_d` out 1; `s0_v` out 1.
- `s1_*`  same set and widths as s0.
- `we`  in  1  write strobe (TLBWI/TLBWR).
- `w_index` in IW; `w_vpn2` in 19; `w_asid` in 8; `w_g` in 1.
- `w_pfn0` in 20; `w_c0` in 3; `w_d0` in 1; `w_v0` in 1.
- `w_pfn1` in 20; `w_c1` in 3; `w_d1` in 1; `w_v1` in 1.
- `r_index`  in  IW  read index (TLBR).
- Read outputs: `r_vpn2` out 19; `r_asid` out 8; `r_g` out 1; `r_pfn0` out 20; `r_c0` out 3; `r_d0` out 1; `r_v0` out 1; `r_pfn1` out 20; `r_c1` out 3; `r_d1` out 1; `r_v1` out 1.
- `rand_index`  out  IW  current random entry for TLBWR.

## Operation
- Per entry: `vpn2`, `asid`, `g`, two page halves {pfn, c, d, v}, plus an internal `e` (entry-exists) bit.
- Reset (`resetn` = 0): all `e` cleared; every other entry field cleared to 0.
- Write: on posedge with `we` = 1, entry `w_index` is loaded with all w_* fields and its `e` is set to 1.
  - `w_g` is stored as given; CP0 already ANDs G0 and G1 before driving it.
- Match for entry i on port k requires all of:
  - `e[i]`
  - `vpn2[i] == sk_vpn2`
  - `g[i]` or `asid[i] == sk_asid`
- `sk_found` = OR of matches.
  - A found entry with v = 0 still reports found = 1 and v = 0; the pipeline raises TLB-invalid from that.
- Multiple matches: lowest matching index wins for index and data; no error is flagged.
- Page select: `sk_odd_page` = 0 returns half 0 ({pfn0, c0, d0, v0}); 1 returns half 1.
- No hit: `sk_index`, `sk_pfn`, `sk_c`, `sk_d`, `sk_v` all drive 0.
- Read: `r_*` reflect entry `r_index` unconditionally, including entries with e = 0 (which read as zero after reset).
- Random counter:
  - Reset to `TLBNUM-1`.
  - Decrements by 1 every cycle.
  - Wraps 0 → `TLBNUM-1`.
  - Not affected by `we`.
  - `rand_index` = counter value.

## Timing
- Lookup and read are combinational, with 0-cycle latency from inputs.
- A write becomes visible to lookup and read on the cycle after the write edge.
- Same-cycle write and lookup/read of the same entry return the old contents.
- Reset values: all `s*` and `r_*` outputs are 0; `rand_index` = `TLBNUM-1`.
- Reset is asserted asynchronously; deassertion is assumed synchronized upstream.
- Reset mid-write: the write is lost and the entry stays cleared.
- Back-to-back writes to the same index: last write wins; each takes one cycle.
- No handshake; `we` is a single-cycle strobe, and CP0 guarantees at most one write per instruction.

## Test plan
- **Reset, then lookup:** `resetn` pulse, `s0_vpn2` = 0, asid = 0 → `s0_found` = 0, `rand_index` = 15; next cycles 14, 13, …, 0, 15.
- **Write, then both ports and ASID check:** `we` with `w_index` = 5, vpn2 = 19'h00010, asid = 8'h3, g = 0, pfn0 = 20'h1234A, v0 = 1, d0 = 1, pfn1 = 20'h5678B, v1 = 0.
  - Next cycle, s0 (odd = 0, asid = 3) → found = 1, index = 5, pfn = 1234A, v = 1, d = 1.
  - s1 (odd = 1, asid = 3) → found = 1, pfn = 5678B, v = 0.
  - Asid = 4 → found = 0.
- **Global entry:** rewrite index 5 with g = 1 → lookup with asid = 8'hFF → found = 1.
- **Duplicate match:** identical vpn2/asid written to indices 9 and 2 → `s1_index` = 2.
- **Write/read collision:** `we` to index 7 with `r_index` = 7 in the same cycle → `r_vpn2` shows the old value that cycle and the new value the next cycle.
- **Async reset mid-run:** assert `resetn` between clock edges → all entries miss immediately and `rand_index` = 15 before the next posedge.

Source files
------------

// File: rtl/tlb.sv
// 16-entry fully associative MIPS32 joint TLB with two combinational lookup ports,
// a TLBR read port, a TLBWI/TLBWR write port and a free-running random index.
module tlb #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic [18:0]   s0_vpn2,
    input  logic          s0_odd_page,
    input  logic [7:0]    s0_asid,
    output logic          s0_found,
    output logic [IW-1:0] s0_index,
    output logic [19:0]   s0_pfn,
    output logic [2:0]    s0_c,
    output logic          s0_d,
    output logic          s0_v,

    input  logic [18:0]   s1_vpn2,
    input  logic          s1_odd_page,
    input  logic [7:0]    s1_asid,
    output logic          s1_found,
    output logic [IW-1:0] s1_index,
    output logic [19:0]   s1_pfn,
    output logic [2:0]    s1_c,
    output logic          s1_d,
    output logic          s1_v,

    input  logic          we,
    input  logic [IW-1:0] w_index,
    input  logic [18:0]   w_vpn2,
    input  logic [7:0]    w_asid,
    input  logic          w_g,
    input  logic [19:0]   w_pfn0,
    input  logic [2:0]    w_c0,
    input  logic          w_d0,
    input  logic          w_v0,
    input  logic [19:0]   w_pfn1,
    input  logic [2:0]    w_c1,
    input  logic          w_d1,
    input  logic          w_v1,

    input  logic [IW-1:0] r_index,
    output logic [18:0]   r_vpn2,
    output logic [7:0]    r_asid,
    output logic          r_g,
    output logic [19:0]   r_pfn0,
    output logic [2:0]    r_c0,
    output logic          r_d0,
    output logic          r_v0,
    output logic [19:0]   r_pfn1,
    output logic [2:0]    r_c1,
    output logic          r_d1,
    output logic          r_v1,

    output logic [IW-1:0] rand_index
);

    typedef struct packed {
        logic        e;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    entry_t        entry_q [TLBNUM];
    entry_t        entry_d [TLBNUM];
    logic [IW-1:0] rand_q;
    logic [IW-1:0] rand_d;

    // Both lookup ports share one search loop; index 0 is port s0, index 1 is port s1.
    logic [1:0][18:0]   q_vpn2;
    logic [1:0]         q_odd;
    logic [1:0][7:0]    q_asid;
    logic [1:0]         hit;
    logic [1:0][IW-1:0] hit_idx;
    logic [1:0][19:0]   hit_pfn;
    logic [1:0][2:0]    hit_c;
    logic [1:0]         hit_d;
    logic [1:0]         hit_v;

    assign q_vpn2 = {s1_vpn2, s0_vpn2};
    assign q_odd  = {s1_odd_page, s0_odd_page};
    assign q_asid = {s1_asid, s0_asid};

    always_comb begin
        entry_d = entry_q;
        if (we) begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (w_index == IW'(i)) begin
                    entry_d[i] = '{e: 1'b1, vpn2: w_vpn2, asid: w_asid, g: w_g,
                                   pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                   pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
                end
            end
        end
        rand_d = (rand_q == '0) ? IW'(TLBNUM - 1) : rand_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= '0;
            end
            rand_q <= IW'(TLBNUM - 1);
        end else begin
            entry_q <= entry_d;
            rand_q  <= rand_d;
        end
    end

    // Scanning from the top down leaves the lowest matching index as the final winner.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        hit_pfn = '0;
        hit_c   = '0;
        hit_d   = '0;
        hit_v   = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (entry_q[i].e && (entry_q[i].vpn2 == q_vpn2[k]) &&
                    (entry_q[i].g || (entry_q[i].asid == q_asid[k]))) begin
                    hit[k]     = 1'b1;
                    hit_idx[k] = IW'(i);
                    if (q_odd[k]) begin
                        hit_pfn[k] = entry_q[i].pfn1;
                        hit_c[k]   = entry_q[i].c1;
                        hit_d[k]   = entry_q[i].d1;
                        hit_v[k]   = entry_q[i].v1;
                    end else begin
                        hit_pfn[k] = entry_q[i].pfn0;
                        hit_c[k]   = entry_q[i].c0;
                        hit_d[k]   = entry_q[i].d0;
                        hit_v[k]   = entry_q[i].v0;
                    end
                end
            end
        end
    end

    assign s0_found = hit[0];
    assign s0_index = hit_idx[0];
    assign s0_pfn   = hit_pfn[0];
    assign s0_c     = hit_c[0];
    assign s0_d     = hit_d[0];
    assign s0_v     = hit_v[0];
    assign s1_found = hit[1];
    assign s1_index = hit_idx[1];
    assign s1_pfn   = hit_pfn[1];
    assign s1_c     = hit_c[1];
    assign s1_d     = hit_d[1];
    assign s1_v     = hit_v[1];

    // TLBR sees the stored fields regardless of the entry-exists bit.
    always_comb begin
        r_vpn2 = '0;
        r_asid = '0;
        r_g    = 1'b0;
        r_pfn0 = '0;
        r_c0   = '0;
        r_d0   = 1'b0;
        r_v0   = 1'b0;
        r_pfn1 = '0;
        r_c1   = '0;
        r_d1   = 1'b0;
        r_v1   = 1'b0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (r_index == IW'(i)) begin
                r_vpn2 = entry_q[i].vpn2;
                r_asid = entry_q[i].asid;
                r_g    = entry_q[i].g;
                r_pfn0 = entry_q[i].pfn0;
                r_c0   = entry_q[i].c0;
                r_d0   = entry_q[i].d0;
                r_v0   = entry_q[i].v0;
                r_pfn1 = entry_q[i].pfn1;
                r_c1   = entry_q[i].c1;
                r_d1   = entry_q[i].d1;
                r_v1   = entry_q[i].v1;
            end
        end
    end

    assign rand_index = rand_q;

endmodule
